// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: operands and op in, result and flags out.
// The master drives operands and consumes results; the ALU itself is the slave.
interface seq_alu_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero_flag;
  logic             div_by_zero;
  logic             illegal_op;

  modport master (
    output in_valid, a, b, alu_op, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero_flag, div_by_zero, illegal_op
  );

  modport slave (
    input  in_valid, a, b, alu_op, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero_flag, div_by_zero, illegal_op
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked integer ALU: single-cycle logic/add/sub/slt plus iterative shift-add multiply
// and restoring unsigned divide/remainder, one bit per cycle.
module seq_alu #(
  parameter int WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_alu_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplier, or divisor
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;
  logic             load_result;

  // Single-cycle datapath, evaluated on the live inputs while idle.
  logic             is_sub, is_addc;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf, alu_ill;

  always_comb begin
    is_sub  = (bus.alu_op == OP_SUB) || (bus.alu_op == OP_SLT);
    is_addc = is_sub || (bus.alu_op == OP_ADD);
    b_eff   = is_sub ? ~bus.b : bus.b;
    sum_ext = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    alu_cout = is_addc ? sum_ext[WIDTH] : 1'b0;
    // Signed overflow: operands agree in sign but the sum does not.
    alu_ovf  = is_addc && (bus.a[WIDTH-1] == b_eff[WIDTH-1])
                       && (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
    alu_ill  = 1'b0;
    alu_res  = '0;
    case (bus.alu_op)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_ADD:  alu_res = sum_ext[WIDTH-1:0];
      OP_SUB:  alu_res = sum_ext[WIDTH-1:0];
      OP_SLT:  alu_res[0] = sum_ext[WIDTH-1];
      OP_NOR:  alu_res = ~bus.a & ~bus.b;
      OP_NAND: alu_res = ~bus.a | ~bus.b;
      default: alu_ill = 1'b1;
    endcase
  end

  // Iterative datapath for MUL and DIV.
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   div_trial, div_diff;
  logic             div_qbit;
  logic [WIDTH-1:0] div_rem, div_quot;
  logic             last_iter;

  always_comb begin
    mul_sum   = acc_q + (opb_q[0] ? opa_q : '0);
    div_trial = {rem_q, opa_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    div_qbit  = ~div_diff[WIDTH];
    div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_quot  = {opa_q[WIDTH-2:0], div_qbit};
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    ill_d       = ill_q;
    load_result = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d   = bus.alu_op;
          cnt_d  = '0;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
          dbz_d  = 1'b0;
          ill_d  = 1'b0;
          case (bus.alu_op)
            OP_MUL: begin
              opa_d   = bus.a;
              opb_d   = bus.b;
              acc_d   = '0;
              state_d = S_MUL;
            end
            OP_DIVU, OP_REMU: begin
              if (bus.b == '0) begin
                result_d    = (bus.alu_op == OP_DIVU) ? '1 : bus.a;
                dbz_d       = 1'b1;
                load_result = 1'b1;
                state_d     = S_DONE;
              end else begin
                opa_d   = bus.a;
                opb_d   = bus.b;
                rem_d   = '0;
                state_d = S_DIV;
              end
            end
            default: begin
              result_d    = alu_res;
              cout_d      = alu_cout;
              ovf_d       = alu_ovf;
              ill_d       = alu_ill;
              load_result = 1'b1;
              state_d     = S_DONE;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_sum;
        opa_d = {opa_q[WIDTH-2:0], 1'b0};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        if (last_iter) begin
          result_d    = mul_sum;
          load_result = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        rem_d = div_rem;
        opa_d = div_quot;
        if (last_iter) begin
          result_d    = (op_q == OP_REMU) ? div_rem : div_quot;
          load_result = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Zero flag only moves with the result so it reads 0 out of reset.
    zero_d = load_result ? (result_d == '0) : zero_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.result      = result_q;
  assign bus.cout        = cout_q;
  assign bus.overflow    = ovf_q;
  assign bus.zero_flag   = zero_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal_op  = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH = 8: a vector table of hand-computed results plus
// hand-written sequences for reset, busy in_ready, output stall and mid-multiply abort.
module tb_seq_alu;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // flags packed as {cout, overflow, zero_flag, div_by_zero, illegal_op}
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [4:0]   flags;
    int           lat;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [4:0] flags_now();
    return {bus.cout, bus.overflow, bus.zero_flag, bus.div_by_zero, bus.illegal_op};
  endfunction

  // Present one op with out_ready high; return the result, flags and accept-to-out_valid latency.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic [4:0] flags, output int lat);
    @(negedge clk);
    bus.alu_op   = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res   = bus.result;
    flags = flags_now();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] res;
    logic [4:0]   flags;
    int           lat;
    int           n_low;
    int           seen;

    vecs[0]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 5'b01000, 1};   // ADD signed overflow
    vecs[1]  = '{4'b0110, 8'h03, 8'h05, 8'hFE, 5'b00000, 1};   // SUB borrow
    vecs[2]  = '{4'b0111, 8'h03, 8'h05, 8'h01, 5'b00000, 1};   // SLT true
    vecs[3]  = '{4'b0110, 8'h5A, 8'h5A, 8'h00, 5'b10100, 1};   // SUB equal
    vecs[4]  = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1};   // AND
    vecs[5]  = '{4'b0001, 8'hF0, 8'h0C, 8'hFC, 5'b00000, 1};   // OR
    vecs[6]  = '{4'b1100, 8'hF0, 8'h0C, 8'h03, 5'b00000, 1};   // NOR
    vecs[7]  = '{4'b1101, 8'hF0, 8'h3C, 8'hCF, 5'b00000, 1};   // NAND
    vecs[8]  = '{4'b1000, 8'h0D, 8'h0B, 8'h8F, 5'b00000, 9};   // MUL
    vecs[9]  = '{4'b1000, 8'hFF, 8'hFF, 8'h01, 5'b00000, 9};   // MUL truncation
    vecs[10] = '{4'b1001, 8'hC8, 8'h07, 8'h1C, 5'b00000, 9};   // DIVU
    vecs[11] = '{4'b1010, 8'hC8, 8'h07, 8'h04, 5'b00000, 9};   // REMU
    vecs[12] = '{4'b1001, 8'h12, 8'h00, 8'hFF, 5'b00010, 1};   // DIVU by zero
    vecs[13] = '{4'b1010, 8'h12, 8'h00, 8'h12, 5'b00010, 1};   // REMU by zero
    vecs[14] = '{4'b1111, 8'h00, 8'h00, 8'h00, 5'b00101, 1};   // illegal 0xF
    vecs[15] = '{4'b0111, 8'h05, 8'h03, 8'h00, 5'b10100, 1};   // SLT false
    vecs[16] = '{4'b0010, 8'hFF, 8'h01, 8'h00, 5'b10100, 1};   // ADD wrap to zero
    vecs[17] = '{4'b1000, 8'h00, 8'h37, 8'h00, 5'b00100, 9};   // MUL zero
    vecs[18] = '{4'b1001, 8'hFF, 8'h01, 8'hFF, 5'b00000, 9};   // DIVU by one
    vecs[19] = '{4'b1010, 8'h07, 8'hC8, 8'h07, 5'b00000, 9};   // REMU a < b
    vecs[20] = '{4'b0010, 8'h80, 8'h80, 8'h00, 5'b11100, 1};   // ADD negative overflow
    vecs[21] = '{4'b0111, 8'h80, 8'h01, 8'h00, 5'b11100, 1};   // SLT raw sign, no correction
    vecs[22] = '{4'b0011, 8'hFF, 8'hFF, 8'h00, 5'b00101, 1};   // illegal 0x3
    vecs[23] = '{4'b1001, 8'h05, 8'h07, 8'h00, 5'b00100, 9};   // DIVU quotient zero

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.alu_op    = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("reset_in_reset", {bus.in_ready, bus.out_valid, bus.result, flags_now()},
          {1'b1, 1'b0, 8'h00, 5'b00000});
    #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_idle", {bus.in_ready, bus.out_valid, bus.result, flags_now()},
          {1'b1, 1'b0, 8'h00, 5'b00000});

    for (int i = 0; i < 24; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, flags, lat);
      check($sformatf("vec%0d_result", i), {24'h0, res}, {24'h0, vecs[i].res});
      check($sformatf("vec%0d_flags", i), {27'h0, flags}, {27'h0, vecs[i].flags});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Busy window of a multiply: in_ready low through 8 iterations plus the DONE cycle.
    @(negedge clk);
    bus.alu_op = 4'b1000; bus.a = 8'h0D; bus.b = 8'h0B; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n_low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      n_low++;
    end
    check("mul_in_ready_low_cycles", n_low, 9);

    // Output stall: held for 5 cycles while a different op is offered.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.alu_op = 4'b0010; bus.a = 8'h7F; bus.b = 8'h01; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.alu_op = 4'b0000; bus.a = 8'h00; bus.b = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_cycle%0d", i),
            {bus.out_valid, bus.in_ready, bus.result, flags_now()},
            {1'b1, 1'b0, 8'h80, 5'b01000});
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("stall_release", {bus.out_valid, bus.in_ready}, 2'b01);

    // Abort: reset pulsed during iteration 4 of a multiply drops the result.
    @(negedge clk);
    bus.alu_op = 4'b1000; bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_reset", {bus.out_valid, bus.in_ready, bus.result}, {1'b0, 1'b1, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    do_op(4'b0010, 8'h01, 8'h02, res, flags, lat);
    check("after_abort_add", {res, flags, lat[7:0]}, {8'h03, 5'b00000, 8'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the combinational 64-bit integer ALU in the uPower datapath. It keeps the same 4-bit operation encoding for the logic, add, subtract and set-less-than operations, with inverted-A and inverted-B semantics. It adds iterative multi-cycle multiply, unsigned divide and remainder. Operands enter and results leave through valid/ready handshakes, so the execute stage can stall on long operations.

## Interface
- WIDTH, 64: operand/result width in bits; any value from 4 to 64 is legal.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a, b  in  WIDTH  operands A and B.
- alu_op  in  4  operation code, sampled on accept.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- cout  out  1  carry out of the adder (ADD/SUB/SLT only, else 0).
- overflow  out  1  signed overflow, carry[WIDTH] ^ carry[WIDTH-1] (ADD/SUB/SLT only, else 0).
- zero_flag  out  1  result == 0.
- div_by_zero  out  1  DIVU/REMU with b == 0.
- illegal_op  out  1  unsupported alu_op.

## Operation
Operation codes:
- 0000 AND.
- 0001 OR.
- 0010 ADD.
- 0110 SUB: a + ~b + 1.
- 0111 SLT: result = {0…, sign bit of (a − b)}; signed compare taken from the raw sign bit, with no overflow correction, matching the existing ALU.
- 1100 NOR: ~a & ~b.
- 1101 NAND: ~a | ~b.
- 1000 MUL: low WIDTH bits of the unsigned product a·b.
- 1001 DIVU: unsigned quotient a / b.
- 1010 REMU: unsigned remainder a % b.
- All other codes: result = 0, illegal_op = 1.

State machine (IDLE, MUL, DIV, DONE):
- IDLE: in_ready = 1. An accept is in_valid & in_ready.
  - Single-cycle ops, illegal ops and divide-by-zero: compute, register the outputs, go to DONE.
  - MUL: latch operands, clear accumulator, count = 0, go to MUL.
  - DIVU/REMU with b ≠ 0: latch, clear remainder register, go to DIV.
- MUL: shift-add, one multiplier bit per cycle, LSB first. Accumulator is WIDTH bits, so the upper product is discarded. After WIDTH iterations, register the result and go to DONE.
- DIV: restoring divide, one quotient bit per cycle, MSB first, using a WIDTH+1-bit partial remainder. After WIDTH iterations, select the quotient or remainder by the latched op and go to DONE.
- DONE: out_valid = 1. All outputs are held stable until out_ready. When out_valid & out_ready, go to IDLE. A new accept is not possible in the same cycle; in_ready is low in DONE.

Divide by zero:
- DIVU: result = all ones.
- REMU: result = a.
- div_by_zero = 1.
- Latency 1, with no iteration.

Flags:
- zero_flag is computed from the final registered result for every op, including MUL/DIV.
- Flags not applicable to an op are driven 0.

Inputs during busy:
- a, b and alu_op are ignored outside IDLE.
- in_valid may stay high; it is not accepted until the block returns to IDLE.

## Timing
- Reset value: state = IDLE and all outputs 0, except in_ready = 1. Reset asserted mid-MUL/DIV or in DONE aborts immediately and drops the pending result.
- Latency from the accept edge to out_valid high:
  - Single-cycle, illegal and divide-by-zero ops: 1 cycle.
  - MUL, DIVU, REMU: WIDTH + 1 cycles.
- Throughput is at best one op per 2 cycles (accept → DONE → IDLE).
- With out_ready held high, out_valid is high for exactly one cycle per op.
- Output stall: out_valid stays high and result and flags stay constant for as long as out_ready is low.
- The iteration counter is ceil(log2(WIDTH+1)) bits wide and does not wrap within an operation.

## Test plan
All scenarios use WIDTH = 8.
- Reset, then idle: in_ready = 1, out_valid = 0, all flags 0.
- ADD a = 0x7F, b = 0x01, out_ready = 1:
  - out_valid one cycle after the accept.
  - result = 0x80, overflow = 1, cout = 0, zero_flag = 0.
- SUB and SLT with a = 0x03, b = 0x05:
  - SUB: result = 0xFE, cout = 0.
  - SLT: result = 0x01.
  - SUB a = b = 0x5A: result = 0x00, zero_flag = 1, cout = 1.
- MUL a = 0x0D, b = 0x0B:
  - in_ready low for 9 cycles.
  - out_valid on cycle 9, result = 0x8F.
  - MUL a = b = 0xFF: result = 0x01, illustrating truncation.
- DIVU a = 0xC8, b = 0x07: result = 0x1C after 9 cycles.
  - REMU with the same operands: result = 0x04.
  - DIVU a = 0x12, b = 0x00: result = 0xFF, div_by_zero = 1, latency 1.
  - REMU a = 0x12, b = 0x00: result = 0x12, div_by_zero = 1.
- Stall and abort:
  - Stall: out_ready low for 5 cycles in DONE keeps result, flags and out_valid held; the next in_valid is not accepted.
  - Abort: rst_n pulsed low on iteration 4 of a MUL gives out_valid = 0, then a fresh ADD completes normally.
  - Illegal op 0x0F: result = 0, illegal_op = 1, zero_flag = 1.
